// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures up to two retired instructions per cycle and
// presents them one at a time to a trace consumer, counting any it has to drop.
module commit_trace_fifo #(
  parameter int DEPTH     = 16,
  parameter bit DROP_NOWB = 1'b0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmt_valid0,
  input  logic                     cmt_valid1,
  input  logic [31:0]              cmt_pc0,
  input  logic [31:0]              cmt_pc1,
  input  logic                     cmt_wen0,
  input  logic                     cmt_wen1,
  input  logic [4:0]               cmt_wnum0,
  input  logic [4:0]               cmt_wnum1,
  input  logic [31:0]              cmt_wdata0,
  input  logic [31:0]              cmt_wdata1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [3:0]               out_wen,
  output logic [4:0]               out_wnum,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [31:0]              cmt_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 70;

  // Entry layout: {wen, wnum[4:0], pc[31:0], wdata[31:0]}
  logic [EW-1:0] entry_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   cmt_total_q, cmt_total_d;

  logic          pop;
  logic          st0, st1;
  logic [1:0]    n_store, n_push;
  logic [CW:0]   free_space;
  logic          push_ok;
  logic [16:0]   drop_sum;
  logic [EW-1:0] entry0, entry1, head;

  always_comb begin
    pop        = (count_q != '0) && out_ready;
    st0        = cmt_valid0 && (!DROP_NOWB || cmt_wen0);
    st1        = cmt_valid1 && (!DROP_NOWB || cmt_wen1);
    n_store    = {1'b0, st0} + {1'b0, st1};
    free_space = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    // A pair that does not fit is dropped as a whole, never split
    push_ok    = ({{(CW-1){1'b0}}, n_store} <= free_space);
    n_push     = push_ok ? n_store : 2'd0;

    count_d     = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d    = wr_ptr_q + AW'(n_push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    cmt_total_d = cmt_total_q + 32'(n_push);

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_store);
    if (!push_ok) begin
      overflow_d = 1'b1;
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    entry0 = {cmt_wen0 && (cmt_wnum0 != 5'd0), cmt_wnum0, cmt_pc0, cmt_wdata0};
    entry1 = {cmt_wen1 && (cmt_wnum1 != 5'd0), cmt_wnum1, cmt_pc1, cmt_wdata1};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      cmt_total_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      cmt_total_q <= cmt_total_d;
    end
  end

  // Storage is left uncleared by reset; the pointers and count alone define validity
  always_ff @(posedge aclk) begin
    if (push_ok && st0) begin
      entry_mem[wr_ptr_q] <= entry0;
    end
    if (push_ok && st1) begin
      entry_mem[wr_ptr_q + AW'(st0)] <= entry1;
    end
  end

  always_comb begin
    head      = entry_mem[rd_ptr_q];
    out_valid = (count_q != '0);
    out_pc    = out_valid ? head[63:32] : 32'd0;
    out_wdata = out_valid ? head[31:0]  : 32'd0;
    out_wnum  = out_valid ? head[68:64] : 5'd0;
    out_wen   = out_valid ? {4{head[69]}} : 4'd0;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign cmt_total = cmt_total_q;

endmodule
